core_ibex_xif_rvfi_gen: RTL and testbench

Producer side of the RVFI retirement trace. It collects per-instruction events from decode (ID), load/store (LSU) and writeback (WB). It buffers in-flight instructions in order and drives one registered RVFI record per retired instruction. The outputs feed the RVFI probe interface consumed by the UVM monitor and the co-simulation scoreboard.

---
 rtl/core_ibex_xif_rvfi_gen_if.sv | 105 ++++++++++
 rtl/core_ibex_xif_rvfi_gen.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_core_ibex_xif_rvfi_gen.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_ibex_xif_rvfi_gen_if.sv
// ---------------------------------------------------------------------------
// core_ibex_xif_rvfi_gen_if
//
// Bundles every event and record signal of the RVFI trace producer.
//
//   ID  group  : id_valid_i / id_ready_o handshake plus instruction word, PC,
//                next PC, privilege mode, source register addresses and
//                values, trap flag, and the irq_taken_i pulse.
//   LSU group  : lsu_valid_i plus address, byte masks and read/write data
//                of the access that completes for the oldest instruction.
//   WB group   : wb_valid_i plus destination register address and value.
//   RVFI group : one registered retirement record (rvfi_*), and err_o.
//
// Modports:
//   slave  - the trace producer (consumes ID/LSU/WB, drives RVFI and err_o)
//   master - the pipeline side (drives ID/LSU/WB, observes RVFI and err_o)
// ---------------------------------------------------------------------------
interface core_ibex_xif_rvfi_gen_if;

    // Decode
    logic        id_valid_i;
    logic        id_ready_o;
    logic [31:0] id_insn_i;
    logic [31:0] id_pc_i;
    logic [31:0] id_pc_next_i;
    logic [1:0]  id_mode_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic [31:0] id_rs1_rdata_i;
    logic [31:0] id_rs2_rdata_i;
    logic        id_trap_i;
    logic        irq_taken_i;

    // Load/store
    logic        lsu_valid_i;
    logic [31:0] lsu_addr_i;
    logic [3:0]  lsu_rmask_i;
    logic [3:0]  lsu_wmask_i;
    logic [31:0] lsu_rdata_i;
    logic [31:0] lsu_wdata_i;

    // Writeback
    logic        wb_valid_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_rd_wdata_i;

    // Retirement record
    logic        rvfi_valid_o;
    logic [63:0] rvfi_order_o;
    logic [31:0] rvfi_insn_o;
    logic [31:0] rvfi_pc_rdata_o;
    logic [31:0] rvfi_pc_wdata_o;
    logic [31:0] rvfi_rs1_rdata_o;
    logic [31:0] rvfi_rs2_rdata_o;
    logic [31:0] rvfi_rd_wdata_o;
    logic [31:0] rvfi_mem_addr_o;
    logic [31:0] rvfi_mem_rdata_o;
    logic [31:0] rvfi_mem_wdata_o;
    logic [4:0]  rvfi_rs1_addr_o;
    logic [4:0]  rvfi_rs2_addr_o;
    logic [4:0]  rvfi_rd_addr_o;
    logic [3:0]  rvfi_mem_rmask_o;
    logic [3:0]  rvfi_mem_wmask_o;
    logic [1:0]  rvfi_mode_o;
    logic [1:0]  rvfi_ixl_o;
    logic        rvfi_trap_o;
    logic        rvfi_intr_o;
    logic        rvfi_halt_o;
    logic        err_o;

    modport slave (
        input  id_valid_i, id_insn_i, id_pc_i, id_pc_next_i, id_mode_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_rdata_i, id_rs2_rdata_i,
               id_trap_i, irq_taken_i,
               lsu_valid_i, lsu_addr_i, lsu_rmask_i, lsu_wmask_i,
               lsu_rdata_i, lsu_wdata_i,
               wb_valid_i, wb_rd_addr_i, wb_rd_wdata_i,
        output id_ready_o,
               rvfi_valid_o, rvfi_order_o, rvfi_insn_o, rvfi_pc_rdata_o,
               rvfi_pc_wdata_o, rvfi_rs1_rdata_o, rvfi_rs2_rdata_o,
               rvfi_rd_wdata_o, rvfi_mem_addr_o, rvfi_mem_rdata_o,
               rvfi_mem_wdata_o, rvfi_rs1_addr_o, rvfi_rs2_addr_o,
               rvfi_rd_addr_o, rvfi_mem_rmask_o, rvfi_mem_wmask_o,
               rvfi_mode_o, rvfi_ixl_o, rvfi_trap_o, rvfi_intr_o,
               rvfi_halt_o, err_o
    );

    modport master (
        output id_valid_i, id_insn_i, id_pc_i, id_pc_next_i, id_mode_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_rdata_i, id_rs2_rdata_i,
               id_trap_i, irq_taken_i,
               lsu_valid_i, lsu_addr_i, lsu_rmask_i, lsu_wmask_i,
               lsu_rdata_i, lsu_wdata_i,
               wb_valid_i, wb_rd_addr_i, wb_rd_wdata_i,
        input  id_ready_o,
               rvfi_valid_o, rvfi_order_o, rvfi_insn_o, rvfi_pc_rdata_o,
               rvfi_pc_wdata_o, rvfi_rs1_rdata_o, rvfi_rs2_rdata_o,
               rvfi_rd_wdata_o, rvfi_mem_addr_o, rvfi_mem_rdata_o,
               rvfi_mem_wdata_o, rvfi_rs1_addr_o, rvfi_rs2_addr_o,
               rvfi_rd_addr_o, rvfi_mem_rmask_o, rvfi_mem_wmask_o,
               rvfi_mode_o, rvfi_ixl_o, rvfi_trap_o, rvfi_intr_o,
               rvfi_halt_o, err_o
    );

endinterface

// File: rtl/core_ibex_xif_rvfi_gen.sv
// ---------------------------------------------------------------------------
// core_ibex_xif_rvfi_gen
//
// Producer side of the RVFI retirement trace. Instructions leaving decode are
// pushed into an in-order circular buffer of DEPTH entries. Memory results
// from the LSU are merged into the oldest entry, and a writeback (or, for an
// instruction that trapped in decode, the mere fact of being oldest) retires
// that entry into a registered RVFI record one cycle later.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset; discards all in-flight entries
//   bus    - slave modport of core_ibex_xif_rvfi_gen_if (ID/LSU/WB events in,
//            RVFI record, id_ready_o and sticky err_o out)
//
// Parameter:
//   DEPTH  - number of in-flight entries; power of two, at least 2
// ---------------------------------------------------------------------------
module core_ibex_xif_rvfi_gen #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    core_ibex_xif_rvfi_gen_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    typedef logic [AW:0]   ptr_t;
    typedef logic [AW-1:0] idx_t;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [1:0]  mode;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic        trap;
        logic        intr;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } entry_t;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
        logic [1:0]  mode;
        logic        trap;
        logic        intr;
    } record_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    logic        pending_intr_q, pending_intr_d;
    logic        err_q, err_d;
    logic [63:0] order_q, order_d;
    logic        rvfi_valid_q, rvfi_valid_d;
    record_t     rec_q, rec_d;

    // Read view of the slot registers (each slot owns its own flops below).
    entry_t      entry_q [DEPTH];

    // -----------------------------------------------------------------------
    // Buffer status and event qualification (registered state only)
    // -----------------------------------------------------------------------
    ptr_t   count;
    logic   empty;
    logic   full;
    idx_t   wr_idx;
    idx_t   rd_idx;
    entry_t head;
    logic   push;
    logic   head_is_trap;
    logic   lsu_ok;
    logic   wb_ok;
    logic   trap_retire;
    logic   retire;
    entry_t push_entry;

    always_comb begin
        count  = wr_ptr_q - rd_ptr_q;
        empty  = (count == '0);
        full   = (count == ptr_t'(DEPTH));
        wr_idx = wr_ptr_q[AW-1:0];
        rd_idx = rd_ptr_q[AW-1:0];
        head   = entry_q[rd_idx];

        head_is_trap = !empty && head.trap;

        // A push is decided on registered fullness; a retirement in the same
        // cycle does not open a slot early.
        push = bus.id_valid_i && !full;

        // LSU and WB events only apply to a non-trap oldest entry.
        lsu_ok = bus.lsu_valid_i && !empty && !head.trap;
        wb_ok  = bus.wb_valid_i  && !empty && !head.trap;

        // A trap entry retires on its own, but yields to a (bogus) writeback
        // in the same cycle so that the error is flagged and nothing retires.
        trap_retire = head_is_trap && !bus.wb_valid_i;
        retire      = wb_ok || trap_retire;
    end

    // New entry built from ID fields; memory fields start cleared.
    always_comb begin
        push_entry           = '0;
        push_entry.insn      = bus.id_insn_i;
        push_entry.pc        = bus.id_pc_i;
        push_entry.pc_next   = bus.id_pc_next_i;
        push_entry.mode      = bus.id_mode_i;
        push_entry.rs1_addr  = bus.id_rs1_addr_i;
        push_entry.rs2_addr  = bus.id_rs2_addr_i;
        push_entry.rs1_rdata = bus.id_rs1_rdata_i;
        push_entry.rs2_rdata = bus.id_rs2_rdata_i;
        push_entry.trap      = bus.id_trap_i;
        // An interrupt taken earlier without a push is attributed to the next
        // instruction that enters the buffer.
        push_entry.intr      = bus.irq_taken_i || pending_intr_q;
    end

    // -----------------------------------------------------------------------
    // Entry slots
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        localparam idx_t SLOT = idx_t'(gi);

        entry_t slot_q, slot_d;

        always_comb begin
            slot_d = slot_q;
            if (push && (wr_idx == SLOT)) begin
                slot_d = push_entry;
            end
            // Push and LSU never target the same slot: that would need the
            // buffer to be empty (LSU rejected) or full (push rejected).
            if (lsu_ok && (rd_idx == SLOT)) begin
                slot_d.mem_addr  = bus.lsu_addr_i;
                slot_d.mem_rmask = bus.lsu_rmask_i;
                slot_d.mem_wmask = bus.lsu_wmask_i;
                slot_d.mem_rdata = bus.lsu_rdata_i;
                slot_d.mem_wdata = bus.lsu_wdata_i;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end

        assign entry_q[gi] = slot_q;
    end

    // -----------------------------------------------------------------------
    // Pointers, interrupt attribution, error flag
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        pending_intr_d = pending_intr_q;
        err_d          = err_q;

        if (push) begin
            wr_ptr_d       = wr_ptr_q + ptr_t'(1);
            pending_intr_d = 1'b0;
        end else if (bus.irq_taken_i) begin
            pending_intr_d = 1'b1;
        end

        if (retire) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end

        // Sticky protocol errors: push into a full buffer, or an LSU/WB event
        // with no eligible oldest entry.
        if ((bus.id_valid_i && full) ||
            (bus.lsu_valid_i && (empty || head.trap)) ||
            (bus.wb_valid_i && (empty || head.trap))) begin
            err_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Retirement record
    // -----------------------------------------------------------------------
    always_comb begin
        rec_d        = rec_q;
        rvfi_valid_d = 1'b0;
        order_d      = order_q;

        if (retire) begin
            rvfi_valid_d    = 1'b1;
            order_d         = order_q + 64'd1;

            rec_d.order     = order_q;
            rec_d.insn      = head.insn;
            rec_d.pc_rdata  = head.pc;
            rec_d.pc_wdata  = head.pc_next;
            rec_d.rs1_addr  = head.rs1_addr;
            rec_d.rs2_addr  = head.rs2_addr;
            rec_d.rs1_rdata = head.rs1_rdata;
            rec_d.rs2_rdata = head.rs2_rdata;
            rec_d.mode      = head.mode;
            rec_d.intr      = head.intr;

            if (trap_retire) begin
                rec_d.trap      = 1'b1;
                rec_d.rd_addr   = '0;
                rec_d.rd_wdata  = '0;
                rec_d.mem_addr  = '0;
                rec_d.mem_rmask = '0;
                rec_d.mem_wmask = '0;
                rec_d.mem_rdata = '0;
                rec_d.mem_wdata = '0;
            end else begin
                rec_d.trap     = 1'b0;
                rec_d.rd_addr  = bus.wb_rd_addr_i;
                // x0 is hardwired to zero whatever the writeback claims.
                rec_d.rd_wdata = (bus.wb_rd_addr_i == 5'd0) ? 32'd0
                                                            : bus.wb_rd_wdata_i;
                // An access completing in the retiring cycle has not reached
                // the slot yet, so forward it straight from the LSU.
                if (lsu_ok) begin
                    rec_d.mem_addr  = bus.lsu_addr_i;
                    rec_d.mem_rmask = bus.lsu_rmask_i;
                    rec_d.mem_wmask = bus.lsu_wmask_i;
                    rec_d.mem_rdata = bus.lsu_rdata_i;
                    rec_d.mem_wdata = bus.lsu_wdata_i;
                end else begin
                    rec_d.mem_addr  = head.mem_addr;
                    rec_d.mem_rmask = head.mem_rmask;
                    rec_d.mem_wmask = head.mem_wmask;
                    rec_d.mem_rdata = head.mem_rdata;
                    rec_d.mem_wdata = head.mem_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            pending_intr_q <= 1'b0;
            err_q          <= 1'b0;
            order_q        <= '0;
            rvfi_valid_q   <= 1'b0;
            rec_q          <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            pending_intr_q <= pending_intr_d;
            err_q          <= err_d;
            order_q        <= order_d;
            rvfi_valid_q   <= rvfi_valid_d;
            rec_q          <= rec_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.id_ready_o       = !full;
    assign bus.err_o            = err_q;

    assign bus.rvfi_valid_o     = rvfi_valid_q;
    assign bus.rvfi_order_o     = rec_q.order;
    assign bus.rvfi_insn_o      = rec_q.insn;
    assign bus.rvfi_pc_rdata_o  = rec_q.pc_rdata;
    assign bus.rvfi_pc_wdata_o  = rec_q.pc_wdata;
    assign bus.rvfi_rs1_addr_o  = rec_q.rs1_addr;
    assign bus.rvfi_rs2_addr_o  = rec_q.rs2_addr;
    assign bus.rvfi_rs1_rdata_o = rec_q.rs1_rdata;
    assign bus.rvfi_rs2_rdata_o = rec_q.rs2_rdata;
    assign bus.rvfi_rd_addr_o   = rec_q.rd_addr;
    assign bus.rvfi_rd_wdata_o  = rec_q.rd_wdata;
    assign bus.rvfi_mem_addr_o  = rec_q.mem_addr;
    assign bus.rvfi_mem_rmask_o = rec_q.mem_rmask;
    assign bus.rvfi_mem_wmask_o = rec_q.mem_wmask;
    assign bus.rvfi_mem_rdata_o = rec_q.mem_rdata;
    assign bus.rvfi_mem_wdata_o = rec_q.mem_wdata;
    assign bus.rvfi_mode_o      = rec_q.mode;
    assign bus.rvfi_trap_o      = rec_q.trap;
    assign bus.rvfi_intr_o      = rec_q.intr;
    assign bus.rvfi_ixl_o       = 2'b01;
    assign bus.rvfi_halt_o      = 1'b0;

endmodule

// File: tb/tb_core_ibex_xif_rvfi_gen.sv
// ---------------------------------------------------------------------------
// tb_core_ibex_xif_rvfi_gen
//
// Directed stimulus for the RVFI trace producer. A queue-based model of the
// in-flight instructions predicts the record after every clock edge; a
// compare process checks all outputs on each falling edge, and the directed
// sequence pins the model with hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_core_ibex_xif_rvfi_gen;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    core_ibex_xif_rvfi_gen_if bus ();

    core_ibex_xif_rvfi_gen #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Model: queue of in-flight instructions and the last emitted record
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [1:0]  mode;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic        trap;
        logic        intr;
        logic [31:0] maddr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] mrdata;
        logic [31:0] mwdata;
        logic [4:0]  rda;
        logic [31:0] rdd;
    } rec_t;

    rec_t        m_q[$];
    rec_t        m_rec;
    rec_t        m_h;
    rec_t        m_new;
    logic        m_valid = 1'b0;
    logic [63:0] m_order = '0;
    logic        m_pend  = 1'b0;
    logic        m_err   = 1'b0;
    bit          m_have;
    bit          m_push;
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_order = '0;
            m_pend  = 1'b0;
            m_err   = 1'b0;
            m_valid = 1'b0;
            m_rec   = '0;
            started = 1'b1;
        end else begin
            m_valid = 1'b0;
            m_have  = (m_q.size() > 0);
            m_push  = bus.id_valid_i && (m_q.size() < DEPTH);
            m_h     = m_have ? m_q[0] : '0;

            if (bus.id_valid_i && !m_push) m_err = 1'b1;

            if (bus.lsu_valid_i) begin
                if (!m_have || m_h.trap) begin
                    m_err = 1'b1;
                end else begin
                    m_h.maddr  = bus.lsu_addr_i;
                    m_h.rmask  = bus.lsu_rmask_i;
                    m_h.wmask  = bus.lsu_wmask_i;
                    m_h.mrdata = bus.lsu_rdata_i;
                    m_h.mwdata = bus.lsu_wdata_i;
                    m_q[0]     = m_h;
                end
            end

            if (bus.wb_valid_i) begin
                if (!m_have || m_h.trap) begin
                    m_err = 1'b1;
                end else begin
                    m_rec     = m_h;
                    m_rec.rda = bus.wb_rd_addr_i;
                    m_rec.rdd = (bus.wb_rd_addr_i == 5'd0) ? 32'd0 : bus.wb_rd_wdata_i;
                    m_valid   = 1'b1;
                end
            end else if (m_have && m_h.trap) begin
                m_rec        = m_h;
                m_rec.maddr  = '0;
                m_rec.rmask  = '0;
                m_rec.wmask  = '0;
                m_rec.mrdata = '0;
                m_rec.mwdata = '0;
                m_rec.rda    = '0;
                m_rec.rdd    = '0;
                m_valid      = 1'b1;
            end

            if (m_valid) begin
                void'(m_q.pop_front());
                m_rec.order = m_order;
                m_order     = m_order + 64'd1;
            end

            if (m_push) begin
                m_new         = '0;
                m_new.insn    = bus.id_insn_i;
                m_new.pc      = bus.id_pc_i;
                m_new.pc_next = bus.id_pc_next_i;
                m_new.mode    = bus.id_mode_i;
                m_new.rs1a    = bus.id_rs1_addr_i;
                m_new.rs2a    = bus.id_rs2_addr_i;
                m_new.rs1d    = bus.id_rs1_rdata_i;
                m_new.rs2d    = bus.id_rs2_rdata_i;
                m_new.trap    = bus.id_trap_i;
                m_new.intr    = bus.irq_taken_i || m_pend;
                m_pend        = 1'b0;
                m_q.push_back(m_new);
            end else if (bus.irq_taken_i) begin
                m_pend = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Compare process: every falling edge once reset has been seen
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (started) begin
            check("ready",     64'(bus.id_ready_o),       64'(m_q.size() < DEPTH));
            check("err",       64'(bus.err_o),            64'(m_err));
            check("valid",     64'(bus.rvfi_valid_o),     64'(m_valid));
            check("order",     bus.rvfi_order_o,          m_rec.order);
            check("insn",      64'(bus.rvfi_insn_o),      64'(m_rec.insn));
            check("pc_rdata",  64'(bus.rvfi_pc_rdata_o),  64'(m_rec.pc));
            check("pc_wdata",  64'(bus.rvfi_pc_wdata_o),  64'(m_rec.pc_next));
            check("rs1_addr",  64'(bus.rvfi_rs1_addr_o),  64'(m_rec.rs1a));
            check("rs2_addr",  64'(bus.rvfi_rs2_addr_o),  64'(m_rec.rs2a));
            check("rs1_rdata", 64'(bus.rvfi_rs1_rdata_o), 64'(m_rec.rs1d));
            check("rs2_rdata", 64'(bus.rvfi_rs2_rdata_o), 64'(m_rec.rs2d));
            check("rd_addr",   64'(bus.rvfi_rd_addr_o),   64'(m_rec.rda));
            check("rd_wdata",  64'(bus.rvfi_rd_wdata_o),  64'(m_rec.rdd));
            check("mem_addr",  64'(bus.rvfi_mem_addr_o),  64'(m_rec.maddr));
            check("mem_rmask", 64'(bus.rvfi_mem_rmask_o), 64'(m_rec.rmask));
            check("mem_wmask", 64'(bus.rvfi_mem_wmask_o), 64'(m_rec.wmask));
            check("mem_rdata", 64'(bus.rvfi_mem_rdata_o), 64'(m_rec.mrdata));
            check("mem_wdata", 64'(bus.rvfi_mem_wdata_o), 64'(m_rec.mwdata));
            check("mode",      64'(bus.rvfi_mode_o),      64'(m_rec.mode));
            check("trap",      64'(bus.rvfi_trap_o),      64'(m_rec.trap));
            check("intr",      64'(bus.rvfi_intr_o),      64'(m_rec.intr));
            check("ixl",       64'(bus.rvfi_ixl_o),       64'd1);
            check("halt",      64'(bus.rvfi_halt_o),      64'd0);
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic idle();
        bus.id_valid_i     = 1'b0;
        bus.id_insn_i      = '0;
        bus.id_pc_i        = '0;
        bus.id_pc_next_i   = '0;
        bus.id_mode_i      = '0;
        bus.id_rs1_addr_i  = '0;
        bus.id_rs2_addr_i  = '0;
        bus.id_rs1_rdata_i = '0;
        bus.id_rs2_rdata_i = '0;
        bus.id_trap_i      = 1'b0;
        bus.irq_taken_i    = 1'b0;
        bus.lsu_valid_i    = 1'b0;
        bus.lsu_addr_i     = '0;
        bus.lsu_rmask_i    = '0;
        bus.lsu_wmask_i    = '0;
        bus.lsu_rdata_i    = '0;
        bus.lsu_wdata_i    = '0;
        bus.wb_valid_i     = 1'b0;
        bus.wb_rd_addr_i   = '0;
        bus.wb_rd_wdata_i  = '0;
    endtask

    // Advance one clock; outputs are then stable for literal checks.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input logic [31:0] insn, input logic [31:0] pc, input logic trap);
        bus.id_valid_i     = 1'b1;
        bus.id_insn_i      = insn;
        bus.id_pc_i        = pc;
        bus.id_pc_next_i   = pc + 32'd4;
        bus.id_mode_i      = pc[5:4];
        bus.id_rs1_addr_i  = insn[19:15];
        bus.id_rs2_addr_i  = insn[24:20];
        bus.id_rs1_rdata_i = pc ^ 32'hA5A5_0000;
        bus.id_rs2_rdata_i = pc + 32'h10;
        bus.id_trap_i      = trap;
    endtask

    task automatic lsu(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] rd, input logic [31:0] wd);
        bus.lsu_valid_i = 1'b1;
        bus.lsu_addr_i  = addr;
        bus.lsu_rmask_i = rm;
        bus.lsu_wmask_i = wm;
        bus.lsu_rdata_i = rd;
        bus.lsu_wdata_i = wd;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_valid_i    = 1'b1;
        bus.wb_rd_addr_i  = a;
        bus.wb_rd_wdata_i = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        idle();
        do_reset();

        // Reset state
        check("rst_valid", 64'(bus.rvfi_valid_o), 64'd0);
        check("rst_order", bus.rvfi_order_o, 64'd0);
        check("rst_ixl",   64'(bus.rvfi_ixl_o), 64'd1);
        check("rst_ready", 64'(bus.id_ready_o), 64'd1);
        check("rst_err",   64'(bus.err_o), 64'd0);
        check("rst_insn",  64'(bus.rvfi_insn_o), 64'd0);

        // ADDI x1, x0, 1 then writeback
        push(32'h0010_0093, 32'h80, 1'b0);
        tick();
        check("addi_nobypass", 64'(bus.rvfi_valid_o), 64'd0);
        wb(5'd1, 32'd1);
        tick();
        check("addi_valid", 64'(bus.rvfi_valid_o), 64'd1);
        check("addi_order", bus.rvfi_order_o, 64'd0);
        check("addi_rd",    64'(bus.rvfi_rd_addr_o), 64'd1);
        check("addi_wdata", 64'(bus.rvfi_rd_wdata_o), 64'd1);
        check("addi_pc",    64'(bus.rvfi_pc_rdata_o), 64'h80);
        check("addi_pcn",   64'(bus.rvfi_pc_wdata_o), 64'h84);
        check("addi_trap",  64'(bus.rvfi_trap_o), 64'd0);
        tick();
        check("addi_pulse", 64'(bus.rvfi_valid_o), 64'd0);

        // LW with separate LSU completion, then SW with LSU+WB coinciding
        do_reset();
        push(32'h0002_a283, 32'h100, 1'b0);
        tick();
        lsu(32'h1000, 4'hF, 4'h0, 32'hDEAD_BEEF, 32'h0);
        tick();
        wb(5'd5, 32'hDEAD_BEEF);
        tick();
        check("lw_maddr", 64'(bus.rvfi_mem_addr_o), 64'h1000);
        check("lw_rmask", 64'(bus.rvfi_mem_rmask_o), 64'hF);
        check("lw_rdata", 64'(bus.rvfi_rd_wdata_o), 64'hDEAD_BEEF);
        check("lw_order", bus.rvfi_order_o, 64'd0);
        push(32'h0050_a023, 32'h104, 1'b0);
        tick();
        lsu(32'h2000, 4'h0, 4'hF, 32'h0, 32'h1234_5678);
        wb(5'd0, 32'h0);
        tick();
        check("sw_wmask", 64'(bus.rvfi_mem_wmask_o), 64'hF);
        check("sw_wdata", 64'(bus.rvfi_mem_wdata_o), 64'h1234_5678);
        check("sw_maddr", 64'(bus.rvfi_mem_addr_o), 64'h2000);
        check("sw_order", bus.rvfi_order_o, 64'd1);

        // Fill, overflow, drain in order
        do_reset();
        push(32'h0000_0013, 32'h200, 1'b0);
        tick();
        push(32'h0000_0013, 32'h204, 1'b0);
        tick();
        check("full_ready", 64'(bus.id_ready_o), 64'd0);
        push(32'h0000_0013, 32'h208, 1'b0);
        tick();
        check("ovf_err", 64'(bus.err_o), 64'd1);
        wb(5'd1, 32'h11);
        tick();
        check("drain0_order", bus.rvfi_order_o, 64'd0);
        check("drain0_pc",    64'(bus.rvfi_pc_rdata_o), 64'h200);
        check("drain_ready",  64'(bus.id_ready_o), 64'd1);
        wb(5'd2, 32'h22);
        tick();
        check("drain1_order", bus.rvfi_order_o, 64'd1);
        check("drain1_pc",    64'(bus.rvfi_pc_rdata_o), 64'h204);

        // Trap entry behind a normal entry retires on the very next cycle
        do_reset();
        push(32'h0000_0013, 32'h300, 1'b0);
        tick();
        push(32'h0000_0073, 32'h304, 1'b1);
        tick();
        wb(5'd3, 32'd7);
        tick();
        check("pre_trap_valid", 64'(bus.rvfi_valid_o), 64'd1);
        check("pre_trap_flag",  64'(bus.rvfi_trap_o), 64'd0);
        tick();
        check("trap_valid", 64'(bus.rvfi_valid_o), 64'd1);
        check("trap_flag",  64'(bus.rvfi_trap_o), 64'd1);
        check("trap_rd",    64'(bus.rvfi_rd_addr_o), 64'd0);
        check("trap_pc",    64'(bus.rvfi_pc_rdata_o), 64'h304);
        check("trap_order", bus.rvfi_order_o, 64'd1);
        tick();
        check("trap_after", 64'(bus.rvfi_valid_o), 64'd0);

        // Deferred interrupt attribution
        do_reset();
        bus.irq_taken_i = 1'b1;
        tick();
        push(32'h0000_0013, 32'h400, 1'b0);
        tick();
        push(32'h0000_0013, 32'h404, 1'b0);
        tick();
        wb(5'd1, 32'd1);
        tick();
        check("irq_intr1", 64'(bus.rvfi_intr_o), 64'd1);
        wb(5'd2, 32'd2);
        tick();
        check("irq_intr0", 64'(bus.rvfi_intr_o), 64'd0);
        check("irq_order", bus.rvfi_order_o, 64'd1);

        // x0 destination, then reset between push and writeback
        do_reset();
        push(32'h0000_0013, 32'h500, 1'b0);
        tick();
        wb(5'd0, 32'h55);
        tick();
        check("x0_valid", 64'(bus.rvfi_valid_o), 64'd1);
        check("x0_wdata", 64'(bus.rvfi_rd_wdata_o), 64'd0);
        push(32'h0000_0013, 32'h508, 1'b0);
        tick();
        reset = 1'b1;
        wb(5'd1, 32'd9);
        tick();
        reset = 1'b0;
        check("rst_mid_valid0", 64'(bus.rvfi_valid_o), 64'd0);
        tick();
        check("rst_mid_valid1", 64'(bus.rvfi_valid_o), 64'd0);
        check("rst_mid_err",    64'(bus.err_o), 64'd0);
        push(32'h0000_0013, 32'h50C, 1'b0);
        tick();
        wb(5'd1, 32'd9);
        tick();
        check("rst_mid_order", bus.rvfi_order_o, 64'd0);
        check("rst_mid_pc",    64'(bus.rvfi_pc_rdata_o), 64'h50C);

        // Protocol errors on an empty buffer and on a trap head
        do_reset();
        lsu(32'h3000, 4'hF, 4'h0, 32'h1, 32'h0);
        tick();
        check("lsu_empty_err", 64'(bus.err_o), 64'd1);
        do_reset();
        wb(5'd1, 32'd1);
        tick();
        check("wb_empty_err",   64'(bus.err_o), 64'd1);
        check("wb_empty_valid", 64'(bus.rvfi_valid_o), 64'd0);
        do_reset();
        push(32'h0000_0073, 32'h600, 1'b1);
        tick();
        wb(5'd1, 32'd1);
        tick();
        check("wb_trap_err",   64'(bus.err_o), 64'd1);
        check("wb_trap_valid", 64'(bus.rvfi_valid_o), 64'd0);
        tick();
        check("trap_late_valid", 64'(bus.rvfi_valid_o), 64'd1);
        check("trap_late_flag",  64'(bus.rvfi_trap_o), 64'd1);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
